// File: rtl/mnist_pkg.sv
// mnist_pkg: shared classifier constants, argmax FSM state type and index-width helper
package mnist_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int ACC_W = 32;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mac_argmax_if.sv
// mac_argmax_if: capture/snapshot input and valid/ready result bus of the argmax readout
interface mac_argmax_if import mnist_pkg::*; #(
  parameter int NUM_PE = NUM_CLASSES,
  parameter int DATA_W = ACC_W
) ();
  localparam int IDX_W = idx_w(NUM_PE);
  logic                     capture;
  logic [NUM_PE*DATA_W-1:0] p_flat;
  logic                     busy;
  logic                     valid;
  logic                     ready;
  logic [IDX_W-1:0]         class_idx;
  logic [DATA_W-1:0]        max_val;
  modport master (output capture, p_flat, ready, input busy, valid, class_idx, max_val);
  modport slave  (input capture, p_flat, ready, output busy, valid, class_idx, max_val);
endinterface

// File: rtl/argmax_cmp.sv
// argmax_cmp: a > b on DATA_W bits; signed when ARGMAX_SIGNED_EN is defined, unsigned otherwise
module argmax_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt
);
`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
`else
  assign gt = a > b;
`endif
endmodule

// File: rtl/mac_argmax.sv
// mac_argmax: snapshot NUM_PE accumulators on capture, scan for the max, report index/value via valid/ready
module mac_argmax import mnist_pkg::*; #(
  parameter int NUM_PE = NUM_CLASSES,
  parameter int DATA_W = ACC_W
) (
  input logic         clk,
  input logic         rst,
  mac_argmax_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_PE);
  state_t            state, state_nx;
  logic [DATA_W-1:0] snap [NUM_PE];
  logic [IDX_W-1:0]  cnt, best_idx, res_idx;
  logic [DATA_W-1:0] best_val, res_val;
  logic              gt, take, last;
  argmax_cmp #(.DATA_W(DATA_W)) u_cmp (.a(snap[cnt]), .b(best_val), .gt(gt));
  // first element always seeds the best; later ones must be strictly greater so ties keep the lowest index
  assign take = cnt == '0 || gt;
  assign last = cnt == IDX_W'(NUM_PE - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.capture ? SCAN : IDLE;
      SCAN:    state_nx = last ? DONE : SCAN;
      DONE:    state_nx = bus.ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= '0;
      res_idx  <= '0;
      res_val  <= '0;
      for (int i = 0; i < NUM_PE; i++) snap[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.capture) begin
        cnt <= '0;
        for (int i = 0; i < NUM_PE; i++) snap[i] <= bus.p_flat[i*DATA_W +: DATA_W];
      end
      if (state == SCAN) begin
        cnt <= cnt + 1'b1;
        if (take) begin
          best_idx <= cnt;
          best_val <= snap[cnt];
        end
        if (last) begin
          res_idx <= take ? cnt : best_idx;
          res_val <= take ? snap[cnt] : best_val;
        end
      end
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.valid     = state == DONE;
  assign bus.class_idx = res_idx;
  assign bus.max_val   = res_val;
endmodule

// File: tb/tb_mac_argmax.sv
// tb_mac_argmax: table-driven argmax vectors plus backpressure, late p_flat change and mid-scan reset sequences
module tb_mac_argmax;
  localparam int N = 10;
  localparam int W = 32;
  typedef struct {
    logic [N*W-1:0] p;
    int             idx;
    logic [W-1:0]   val;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int compared = 0;
  int mismatched = 0;
  vec_t v [6];
  mac_argmax_if #(.NUM_PE(N), .DATA_W(W)) bus ();
  mac_argmax #(.NUM_PE(N), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string name, input vec_t t);
    int n;
    bus.p_flat = t.p;
    bus.capture = 1;
    tick();
    bus.capture = 0;
    chk({name, "_busy"}, 64'(bus.busy), 64'd1);
    wait_valid(name, n);
    chk({name, "_lat"}, 64'(n), 64'd10);
    chk({name, "_idx"}, 64'(bus.class_idx), 64'(t.idx));
    chk({name, "_val"}, 64'(bus.max_val), 64'(t.val));
    bus.ready = 1;
    tick();
    bus.ready = 0;
    chk({name, "_drop"}, 64'({bus.valid, bus.busy}), 64'd0);
  endtask

  initial begin
    int n;
    bit stable;
    bus.capture = 0;
    bus.ready = 0;
    bus.p_flat = '0;
    for (int i = 0; i < N; i++) begin
      v[0].p[i*W +: W] = W'(10 * i);
      v[1].p[i*W +: W] = (i == 3 || i == 7) ? 32'd500 : 32'd1;
      v[2].p[i*W +: W] = (i == 2) ? 32'hFFFF_FFFF : (i == 5) ? 32'd100 : 32'd0;
      v[3].p[i*W +: W] = 32'd7;
      v[4].p[i*W +: W] = (i == 0) ? 32'h8000_0000 : 32'd5;
      v[5].p[i*W +: W] = W'(100 - i);
    end
    v[0].idx = 9; v[0].val = 32'd90;
    v[1].idx = 3; v[1].val = 32'd500;
    v[3].idx = 0; v[3].val = 32'd7;
    v[5].idx = 0; v[5].val = 32'd100;
`ifdef ARGMAX_SIGNED_EN
    v[2].idx = 5; v[2].val = 32'd100;
    v[4].idx = 1; v[4].val = 32'd5;
`else
    v[2].idx = 2; v[2].val = 32'hFFFF_FFFF;
    v[4].idx = 0; v[4].val = 32'h8000_0000;
`endif
    tick();
    tick();
    rst = 0;
    chk("rst_flags", 64'({bus.valid, bus.busy}), 64'd0);
    chk("rst_idx", 64'(bus.class_idx), 64'd0);
    chk("rst_val", 64'(bus.max_val), 64'd0);
    for (int k = 0; k < 6; k++) run($sformatf("vec%0d", k), v[k]);
    // backpressure with an ignored capture while DONE
    bus.p_flat = v[0].p;
    bus.capture = 1;
    tick();
    bus.capture = 0;
    wait_valid("bp", n);
    chk("bp_lat", 64'(n), 64'd10);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        bus.p_flat = v[1].p;
        bus.capture = 1;
      end
      tick();
      bus.capture = 0;
      if (!bus.valid || !bus.busy || bus.class_idx != 4'd9 || bus.max_val != 32'd90) stable = 0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    // handshake and capture in the same cycle: capture must be dropped
    bus.ready = 1;
    bus.capture = 1;
    tick();
    bus.ready = 0;
    bus.capture = 0;
    chk("bp_hs_flags", 64'({bus.valid, bus.busy}), 64'd0);
    chk("bp_hold_idx", 64'(bus.class_idx), 64'd9);
    tick();
    chk("bp_no_queue", 64'(bus.busy), 64'd0);
    run("bp_fresh", v[1]);
    // p_flat changes right after the capture edge
    bus.p_flat = v[0].p;
    bus.capture = 1;
    tick();
    bus.capture = 0;
    bus.p_flat = '1;
    wait_valid("late", n);
    chk("late_lat", 64'(n), 64'd10);
    chk("late_idx", 64'(bus.class_idx), 64'd9);
    chk("late_val", 64'(bus.max_val), 64'd90);
    bus.ready = 1;
    tick();
    bus.ready = 0;
    // reset in the middle of a scan
    bus.p_flat = v[5].p;
    bus.capture = 1;
    tick();
    bus.capture = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_flags", 64'({bus.valid, bus.busy}), 64'd0);
    chk("mrst_idx", 64'(bus.class_idx), 64'd0);
    chk("mrst_val", 64'(bus.max_val), 64'd0);
    run("mrst_after", v[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mac_argmax.md
# mac_argmax

Downstream readout stage for the systolic MAC array: once the PEs' accumulation is frozen, it snapshots all NUM_PE accumulator outputs in one cycle and scans them sequentially. It reports the index of the largest score (the predicted MNIST digit) and the winning value over a valid/ready handshake. It sits between the PE array and the picoRV32-facing result register.

## Interface
- NUM_PE, 10: number of PE accumulators (classes) examined; 2..256
- DATA_W, 32: width of each accumulator word
- IDX_W (localparam), $clog2(NUM_PE): class index width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- capture  in  1  one-cycle pulse: snapshot p_flat and start scan; honoured only in IDLE
- p_flat  in  NUM_PE*DATA_W  concatenated PE outputs; PE i at bits [i*DATA_W +: DATA_W]
- busy  out  1  high in SCAN and DONE
- valid  out  1  result available
- ready  in  1  consumer accepts result
- class_idx  out  IDX_W  index of maximum score
- max_val  out  DATA_W  maximum score

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: capture=1 -> latch all NUM_PE words into snapshot regs, clear scan counter to 0, go SCAN. capture=0 -> stay.
- SCAN: each cycle compare snapshot[cnt] with running best. cnt==0 loads best unconditionally (best_val=snap[0], best_idx=0). cnt>0 replaces best only if snap[cnt] strictly greater, so ties resolve to the lowest index. After cnt==NUM_PE-1 is processed -> DONE; otherwise cnt+1.
- DONE: valid=1, class_idx/max_val hold the final best; stable until valid&&ready, then -> IDLE on the next edge.
- capture in SCAN or DONE is ignored (no re-snapshot, no queueing). capture in the same cycle as the DONE handshake is also ignored.
- p_flat is sampled only on the capture edge; later changes do not affect the result.
- Comparison uses full DATA_W bits. There is no arithmetic on scores; max_val is the unmodified snapshot word.
- class_idx/max_val outside DONE: hold the last result (0 after reset). They are qualified only by valid.

## Timing
- Reset: state=IDLE, busy=0, valid=0, class_idx=0, max_val=0, counter and snapshot cleared. Reset in any state aborts immediately. The next capture is honoured the cycle after rst deasserts.
- capture sampled at edge E0 -> busy=1 after E0. The scan runs on edges E1..E_NUM_PE. valid=1 after edge E_NUM_PE, so the latency is NUM_PE cycles from capture to valid (10 by default).
- valid&&ready at edge Ek -> valid=0, busy=0 after Ek. The earliest next capture is accepted at Ek+1.
- Throughput: one result per NUM_PE+2 cycles with ready tied high.
- ready while not valid: no effect.

## Configuration
- ARGMAX_SIGNED_EN defined: scores are compared as two's-complement signed (0xFFFFFFFF = -1).
- Not defined: scores are compared unsigned (0xFFFFFFFF is the largest).
- Affects only the comparator. The handshake, latency and tie rule are identical in both builds.

## Structure
- Shared package mnist_pkg: NUM_CLASSES=10, ACC_W=32, the state enum type (IDLE/SCAN/DONE), and the IDX_W derivation helper.
- One sub-module, argmax_cmp: combinational a>b on DATA_W. This is the sole location of the ARGMAX_SIGNED_EN switch.
- Top level contains the FSM, the snapshot register file, the scan counter and the best registers.

## Test plan
- Scores 0..9 with PE i = 10*i. Pulse capture, ready=1 -> valid exactly 10 cycles after capture; class_idx=9, max_val=90. valid drops the next cycle.
- Tie: PE3=PE7=500, others 1 -> class_idx=3, max_val=500.
- PE2=0xFFFFFFFF, PE5=100, others 0 -> unsigned build: class_idx=2; with ARGMAX_SIGNED_EN: class_idx=5, max_val=100.
- Backpressure and ignored capture: ready=0 for 20 cycles after valid -> outputs stable and busy=1. Pulse capture with new p_flat while in DONE -> ignored. Raise ready -> handshake. A fresh capture then yields the new result.
- p_flat changed to all-0xFF-pattern on the cycle after capture -> result still reflects the snapshot taken at capture.
- Reset mid-SCAN at cycle 4 -> valid=0, busy=0, class_idx=0, max_val=0 next cycle. A subsequent capture completes normally in 10 cycles.
